// File: rtl/ddr3_req_arbiter.sv
// Round-robin, open-row-preferring arbiter that shares one ddr3_mem_cont CPU port
// between NUM_REQ masters; runs one command at a time and routes the response back.
module ddr3_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_HIT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  cpu_clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_cmd,
    input  logic [NUM_REQ*3-1:0]  req_ba,
    input  logic [NUM_REQ*15-1:0] req_addr,
    input  logic [NUM_REQ*10-1:0] req_col,
    input  logic [NUM_REQ*64-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_err,
    input  logic                  mc_cmd_rdy,
    output logic                  mc_addr_valid,
    output logic                  mc_cmd,
    output logic [2:0]            mc_ba,
    output logic [14:0]           mc_addr,
    output logic [9:0]            mc_col,
    output logic [63:0]           mc_wr_data,
    input  logic [63:0]           mc_rd_data,
    input  logic                  mc_done,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HIT_W = $clog2(MAX_HIT + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int ROW_W = 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [HIT_W-1:0]   hit_cnt_q,  hit_cnt_d;
    logic               row_vld_q,  row_vld_d;
    logic [ROW_W-1:0]   last_row_q, last_row_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic               cmd_q,      cmd_d;
    logic [2:0]         ba_q,       ba_d;
    logic [14:0]        addr_q,     addr_d;
    logic [9:0]         col_q,      col_d;
    logic [63:0]        wdata_q,    wdata_d;
    logic [TMR_W-1:0]   timer_q,    timer_d;
    logic [63:0]        rdata_q,    rdata_d;
    logic               err_q,      err_d;

    logic [NUM_REQ-1:0] hit_vec;
    logic [NUM_REQ-1:0] pick_vec;
    logic               hit_any;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               grant;

    // Winner search: the hit set when it is allowed and non-empty, else every valid request.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        hit_vec   = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_vec[i] = req_valid[i] && row_vld_q && (hit_cnt_q < HIT_W'(MAX_HIT)) &&
                         ({req_ba[3*i +: 3], req_addr[15*i +: 15]} == last_row_q);
        end
        hit_any  = |hit_vec;
        pick_vec = hit_any ? hit_vec : req_valid;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && pick_vec[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // A grant is never shown while reset is held, so outputs stay quiet through reset.
    assign grant = (state_q == S_IDLE) && win_found && !reset;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hit_cnt_d  = hit_cnt_q;
        row_vld_d  = row_vld_q;
        last_row_d = last_row_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        ba_d       = ba_q;
        addr_d     = addr_q;
        col_d      = col_q;
        wdata_d    = wdata_q;
        timer_d    = timer_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d    = win_idx;
                    cmd_d      = req_cmd[win_idx];
                    ba_d       = req_ba[int'(win_idx)*3 +: 3];
                    addr_d     = req_addr[int'(win_idx)*15 +: 15];
                    col_d      = req_col[int'(win_idx)*10 +: 10];
                    wdata_d    = req_wdata[int'(win_idx)*64 +: 64];
                    rr_ptr_d   = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
                    last_row_d = {req_ba[int'(win_idx)*3 +: 3], req_addr[int'(win_idx)*15 +: 15]};
                    row_vld_d  = 1'b1;
                    if (!hit_any) begin
                        hit_cnt_d = '0;
                    end else if (hit_cnt_q < HIT_W'(MAX_HIT)) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mc_cmd_rdy) begin
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_q + 1'b1;
                if (mc_done) begin
                    rdata_d = cmd_q ? mc_rd_data : 64'd0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        // NOTE: datapath registers are reset too because they feed outputs that must read 0 in reset.
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            hit_cnt_q  <= '0;
            row_vld_q  <= 1'b0;
            last_row_q <= '0;
            owner_q    <= '0;
            cmd_q      <= 1'b0;
            ba_q       <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            timer_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hit_cnt_q  <= hit_cnt_d;
            row_vld_q  <= row_vld_d;
            last_row_q <= last_row_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
            timer_q    <= timer_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_rdata     = (state_q == S_RESP) ? rdata_q : 64'd0;
    assign rsp_err       = (state_q == S_RESP) && err_q;
    assign mc_addr_valid = (state_q == S_ISSUE);
    assign mc_cmd        = cmd_q;
    assign mc_ba         = ba_q;
    assign mc_addr       = addr_q;
    assign mc_col        = col_q;
    assign mc_wr_data    = wdata_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed plus randomized bench for ddr3_req_arbiter, checked against a
// transaction-level model of the arbitration and response rules.
module tb_ddr3_req_arbiter;

    localparam int N  = 4;
    localparam int MH = 2;
    localparam int TO = 64;

    logic            cpu_clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_cmd;
    logic [N*3-1:0]  req_ba;
    logic [N*15-1:0] req_addr;
    logic [N*10-1:0] req_col;
    logic [N*64-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [63:0]     rsp_rdata;
    logic            rsp_err;
    logic            mc_cmd_rdy;
    logic            mc_addr_valid;
    logic            mc_cmd;
    logic [2:0]      mc_ba;
    logic [14:0]     mc_addr;
    logic [9:0]      mc_col;
    logic [63:0]     mc_wr_data;
    logic [63:0]     mc_rd_data;
    logic            mc_done;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // transaction-level model state
    int          m_rr;
    int          m_hit;
    bit          m_row_vld;
    logic [17:0] m_row;

    ddr3_req_arbiter #(.NUM_REQ(N), .MAX_HIT(MH), .TIMEOUT(TO)) dut (
        .cpu_clk      (cpu_clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_ba       (req_ba),
        .req_addr     (req_addr),
        .req_col      (req_col),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mc_cmd_rdy   (mc_cmd_rdy),
        .mc_addr_valid(mc_addr_valid),
        .mc_cmd       (mc_cmd),
        .mc_ba        (mc_ba),
        .mc_addr      (mc_addr),
        .mc_col       (mc_col),
        .mc_wr_data   (mc_wr_data),
        .mc_rd_data   (mc_rd_data),
        .mc_done      (mc_done),
        .busy         (busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [17:0] row_of(input int i);
        return {req_ba[3*i +: 3], req_addr[15*i +: 15]};
    endfunction

    function automatic int model_pick();
        if (m_row_vld && m_hit < MH) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_rr + k) % N] && row_of((m_rr + k) % N) == m_row) return (m_rr + k) % N;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        bit hit;
        hit       = m_row_vld && (m_hit < MH) && (row_of(w) == m_row);
        m_hit     = hit ? ((m_hit < MH) ? m_hit + 1 : MH) : 0;
        m_rr      = (w + 1) % N;
        m_row     = row_of(w);
        m_row_vld = 1'b1;
    endtask

    task automatic model_reset();
        m_rr = 0; m_hit = 0; m_row_vld = 1'b0; m_row = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic c, input logic [2:0] b,
                           input logic [14:0] a, input logic [9:0] col, input logic [63:0] wd);
        req_valid[i]         = v;
        req_cmd[i]           = c;
        req_ba[3*i +: 3]     = b;
        req_addr[15*i +: 15] = a;
        req_col[10*i +: 10]  = col;
        req_wdata[64*i +: 64] = wd;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_rsp_valid"}, rsp_valid, '0);
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check({tag, "_rsp_err"},   rsp_err, 0);
        check({tag, "_addr_vld"},  mc_addr_valid, 0);
        check({tag, "_mc_cmd"},    mc_cmd, 0);
        check({tag, "_mc_ba"},     mc_ba, 0);
        check({tag, "_mc_addr"},   mc_addr, 0);
        check({tag, "_mc_col"},    mc_col, 0);
        check({tag, "_mc_wdata"},  mc_wr_data, 0);
        check({tag, "_busy"},      busy, 0);
    endtask

    // Entered at a negedge with the DUT idle and requests already driven; returns at
    // the negedge of the cycle after the response.
    task automatic run_txn(input int dir_w, input int rdy_dly, input int done_dly,
                           input bit no_done, input logic [63:0] rd, output int w);
        logic        c;
        logic [2:0]  b;
        logic [14:0] a;
        logic [9:0]  col;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        #1;
        w = model_pick();
        check("idle_busy", busy, 0);
        check("grant", req_ready, oh(w));
        if (dir_w >= 0) check("dir_grant", req_ready, oh(dir_w));
        if (w < 0) begin
            @(negedge cpu_clk);
            return;
        end
        c   = req_cmd[w];
        b   = req_ba[3*w +: 3];
        a   = req_addr[15*w +: 15];
        col = req_col[10*w +: 10];
        wd  = req_wdata[64*w +: 64];
        model_grant(w);
        @(negedge cpu_clk);
        for (int d = 0; d <= rdy_dly; d++) begin
            mc_cmd_rdy = (d == rdy_dly);
            mc_done    = 1'($urandom_range(0, 1));
            #1;
            check("iss_addr_valid", mc_addr_valid, 1);
            check("iss_cmd", mc_cmd, c);
            check("iss_ba", mc_ba, b);
            check("iss_addr", mc_addr, a);
            check("iss_col", mc_col, col);
            check("iss_wdata", mc_wr_data, wd);
            check("iss_no_grant", req_ready, '0);
            check("iss_no_rsp", rsp_valid, '0);
            @(negedge cpu_clk);
        end
        mc_cmd_rdy = 1'b0;
        mc_done    = 1'b0;
        if (no_done) begin
            for (int t = 0; t < TO; t++) begin
                #1;
                check("wt_addr_valid", mc_addr_valid, 0);
                check("wt_no_rsp", rsp_valid, '0);
                check("wt_no_grant", req_ready, '0);
                @(negedge cpu_clk);
            end
        end else begin
            for (int t = 0; t <= done_dly; t++) begin
                mc_done    = (t == done_dly);
                mc_rd_data = (t == done_dly) ? rd : {$urandom, $urandom};
                #1;
                check("wd_addr_valid", mc_addr_valid, 0);
                check("wd_no_rsp", rsp_valid, '0);
                check("wd_no_grant", req_ready, '0);
                @(negedge cpu_clk);
            end
            mc_done = 1'b0;
        end
        exp_rd = (no_done || !c) ? 64'd0 : rd;
        #1;
        check("rsp_valid", rsp_valid, oh(w));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, no_done);
        check("rsp_no_grant", req_ready, '0);
        check("rsp_busy", busy, 1);
        @(negedge cpu_clk);
        mc_rd_data = {$urandom, $urandom};
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge cpu_clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int w;
        int last_w;
        reset = 1'b1;
        req_valid = '0; req_cmd = '0; req_ba = '0; req_addr = '0; req_col = '0; req_wdata = '0;
        mc_cmd_rdy = 1'b0; mc_done = 1'b0; mc_rd_data = '0;
        model_reset();
        repeat (3) @(negedge cpu_clk);
        #1;
        check_quiet("reset");
        @(negedge cpu_clk);
        reset = 1'b0;
        #1;
        check_quiet("post_reset");
        @(negedge cpu_clk);

        // single read, done on the third WAIT_DONE cycle -> response at G+5
        set_req(0, 1, 1, 3'd2, 15'h0010, 10'h004, 64'h1111);
        run_txn(0, 0, 2, 0, 64'hDEADBEEF01234567, w);
        req_valid = '0;

        // fairness across four distinct rows, fresh row after each grant
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 3'(i), 15'(16'h0100 + i), 10'(i), 64'(i));
        for (int g = 0; g < 5; g++) begin
            run_txn(g % N, g % 2, g, 0, {$urandom, $urandom}, w);
            if (w >= 0) req_addr[15*w +: 15] = 15'(16'h0200 + 16'(g * 16));
        end
        req_valid = '0;

        // row-hit preference capped at MAX_HIT, then hit_cnt restarts
        pulse_reset();
        set_req(1, 1, 1, 3'd1, 15'h0020, 10'h001, 64'h0);
        run_txn(1, 0, 0, 0, 64'hA1, w);
        set_req(1, 0, 1, 3'd1, 15'h0020, 10'h001, 64'h0);
        set_req(0, 1, 1, 3'd0, 15'h0030, 10'h002, 64'h0);
        set_req(2, 1, 1, 3'd1, 15'h0020, 10'h003, 64'h0);
        set_req(3, 1, 0, 3'd1, 15'h0020, 10'h004, 64'h5);
        run_txn(2, 1, 1, 0, 64'hA2, w);
        run_txn(3, 0, 0, 0, 64'hA3, w);
        run_txn(0, 0, 0, 0, 64'hA4, w);
        run_txn(0, 2, 1, 0, 64'hA5, w);
        req_valid = '0;

        // write: zero read data returned, latched write data presented
        set_req(1, 1, 0, 3'd3, 15'h0055, 10'h3FF, 64'h0123456789ABCDEF);
        run_txn(1, 3, 1, 0, 64'hFFFF_0000_FFFF_0000, w);
        req_valid = '0;

        // done on the last allowed WAIT_DONE cycle, then a full timeout
        set_req(2, 1, 1, 3'd4, 15'h0777, 10'h010, 64'h0);
        run_txn(-1, 0, TO - 1, 0, 64'hCAFE_F00D_0000_0001, w);
        run_txn(-1, 1, 0, 1, 64'hBAD, w);
        req_valid = '0;

        // randomized traffic
        last_w = -1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                if (i == last_w || !req_valid[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                            15'(16'h0020 + 16'($urandom_range(0, 1))), 10'($urandom), {$urandom, $urandom});
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (req_valid == '0) req_valid[$urandom_range(0, N - 1)] = 1'b1;
            run_txn(-1, $urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                    {$urandom, $urandom}, w);
            last_w = w;
        end
        req_valid = '0;

        // reset while waiting for completion: request dropped, no response
        set_req(0, 1, 1, 3'd5, 15'h0123, 10'h005, 64'h0);
        #1;
        check("mid_grant", req_ready, oh(model_pick()));
        @(negedge cpu_clk);
        mc_cmd_rdy = 1'b1;
        @(negedge cpu_clk);
        mc_cmd_rdy = 1'b0;
        @(negedge cpu_clk);
        #1;
        check("mid_in_wait", busy, 1);
        reset     = 1'b1;
        req_valid = '1;
        #1;
        check("mid_rst_no_grant", req_ready, '0);
        @(negedge cpu_clk);
        #1;
        check_quiet("mid_rst");
        @(negedge cpu_clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 3'(i), 15'(16'h0300 + i), 10'(i), 64'(i));
        run_txn(0, 0, 0, 0, 64'h5A5A, w);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
